// File: rtl/mem_pkg.sv
// Shared definitions for the mem_sync block: FSM state encoding and default
// geometry (8-bit words, 32-word depth).
package mem_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned AWIDTH_DEF = 5;

  // CLEAR zero-fills the array after reset; READY serves reads and writes.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_sync_if.sv
// Request/response bundle between a requester (master) and mem_sync (slave).
//   read, write : request strobes, sampled on each rising clock edge
//   addr, wdata : word address and write data
//   rdata       : registered read data, held while rvalid is low
//   rvalid      : one-cycle pulse marking new rdata
//   busy        : high while the post-reset clear runs
//   err         : one-cycle pulse flagging a rejected or conflicting request
interface mem_sync_if
  import mem_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
);

  logic              read;
  logic              write;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              err;

  modport master (
    output read, write, addr, wdata,
    input  rdata, rvalid, busy, err
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, rvalid, busy, err
  );

endinterface : mem_sync_if

// File: rtl/mem_sync_array.sv
// Word storage for mem_sync: one write port and one synchronous read port.
// The read register resets to zero and holds its value when i_re is low.
// Ports:
//   clk, reset : clock and synchronous active-high reset (read register only)
//   i_we, i_waddr, i_wdata : write port
//   i_re, i_raddr          : read request; data appears on o_rdata after the edge
//   o_rdata                : registered read data
module mem_sync_array
  import mem_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  // Storage is not reset; the controller zero-fills it through the write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Synchronous read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : mem_sync_array

// File: rtl/mem_sync.sv
// Synchronous single-port memory with a post-reset zero-fill sequence.
// After reset the controller spends DEPTH cycles writing zero to every word
// (busy high, requests rejected with err), then serves one read or write per
// cycle with a read latency of one clock.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous active-high reset; restarts the clear sequence
//   bus   : mem_sync_if slave (read, write, addr, wdata / rdata, rvalid, busy, err)
module mem_sync
  import mem_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mem_sync_if.slave  bus
);

  localparam int unsigned       DEPTH     = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_clr_cnt;
  logic [AWIDTH-1:0] w_clr_cnt_nxt;
  logic              r_rvalid;
  logic              r_err;
  logic              r_busy;

  logic              w_we;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_wdata;
  logic              w_re;
  logic              w_err_nxt;
  logic [DWIDTH-1:0] w_rdata;

  // State, counter and flag registers; reset cancels pending rvalid/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_rvalid  <= w_re;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt == CLEAR);
    end
  end

  // Next-state, array port steering and error detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we          = 1'b0;
    w_waddr       = bus.addr;
    w_wdata       = bus.wdata;
    w_re          = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_clr_cnt;
        w_wdata   = '0;
        w_err_nxt = bus.read | bus.write;
        // Counter parks on the last word rather than wrapping.
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = READY;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + AWIDTH'(1);
        end
      end
      READY: begin
        // A simultaneous read is dropped in favour of the write.
        w_we      = bus.write;
        w_re      = bus.read & ~bus.write;
        w_err_nxt = bus.read & bus.write;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Reset blocks any array access on the edge it is sampled.
  mem_sync_array #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we & ~reset),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re & ~reset),
    .i_raddr (bus.addr),
    .o_rdata (w_rdata)
  );

  assign bus.rdata  = w_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;

endmodule : mem_sync

// File: tb/tb_mem_sync.sv
// Self-checking bench for mem_sync: a behavioural memory model tracks every
// cycle, plus a vector table and directed sequences for the clear/reset cases.
module tb_mem_sync;

  logic clk;
  logic reset;

  mem_sync_if #(.DWIDTH(8), .AWIDTH(5)) bus ();

  mem_sync #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_mem [32];
  int         m_clear_left = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_rvalid = 1'b0;
  logic       m_err = 1'b0;
  bit         m_known = 1'b0;

  typedef struct {
    logic       rst;
    logic       rd;
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
    logic       e_rv;
    logic       e_err;
    logic       e_busy;
    logic       chk_rd;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the request rules rather than the RTL.
  task automatic model_edge(input logic r, input logic rd, input logic wr,
                            input logic [4:0] a, input logic [7:0] d);
    if (r) begin
      m_known      = 1'b1;
      m_clear_left = 32;
      m_rdata      = 8'h00;
      m_rvalid     = 1'b0;
      m_err        = 1'b0;
    end else if (m_clear_left > 0) begin
      m_mem[32 - m_clear_left] = 8'h00;
      m_clear_left--;
      m_rvalid = 1'b0;
      m_err    = rd | wr;
    end else begin
      m_rvalid = rd & ~wr;
      if (rd && !wr) m_rdata = m_mem[a];
      if (wr) m_mem[a] = d;
      m_err = rd & wr;
    end
  endtask

  task automatic cycle(input logic r, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] d);
    reset      = r;
    bus.read   = rd;
    bus.write  = wr;
    bus.addr   = a;
    bus.wdata  = d;
    @(posedge clk);
    model_edge(r, rd, wr, a, d);
    #1;
    if (m_known) begin
      check("model_rdata",  32'(bus.rdata),  32'(m_rdata));
      check("model_rvalid", 32'(bus.rvalid), 32'(m_rvalid));
      check("model_err",    32'(bus.err),    32'(m_err));
      check("model_busy",   32'(bus.busy),   32'(m_clear_left > 0));
    end
  endtask

  // Reset, then count the cycles busy stays high (bounded).
  task automatic reset_and_count(output int n);
    n = 0;
    cycle(1, 0, 0, 0, 0);
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      cycle(0, 0, 0, 0, 0);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      cycle(0, 0, 0, 0, 0);
      k++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int errs;

    reset = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset release: 32 busy cycles, all words read back zero
    reset_and_count(n);
    check("busy_len_initial", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 0, 5'(i), 8'h00);
      check("clear_read_val", 32'(bus.rdata), 32'd0);
      check("clear_read_rv",  32'(bus.rvalid), 32'd1);
    end

    // Write data=addr, then read back-to-back
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 5'(i), 8'(i));
    pulses = 0;
    errs   = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 0, 5'(i), 8'h00);
      check("b2b_rdata", 32'(bus.rdata), 32'(i));
      if (bus.rvalid === 1'b1) pulses++;
      if (bus.err !== 1'b0) errs++;
    end
    check("b2b_pulses", 32'(pulses), 32'd32);
    check("b2b_err",    32'(errs),   32'd0);

    // Vector table; memory holds data=addr, rdata last showed 8'h1F
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 5'd5,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'd5,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 5'd3,  8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd3,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd31, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 5'd3,  8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid), 32'(tbl[i].e_rv));
      check($sformatf("vec%0d_err", i),    32'(bus.err),    32'(tbl[i].e_err));
      check($sformatf("vec%0d_busy", i),   32'(bus.busy),   32'(tbl[i].e_busy));
      if (tbl[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].e_rdata));
    end
    wait_idle("vec_idle_timeout");
    cycle(0, 1, 0, 5'd3, 8'h00);
    check("reset_cleared_word3", 32'(bus.rdata), 32'd0);

    // Write attempted during clear is rejected and leaves word 0 at zero
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 5'd0, 8'hFF);
    check("clear_write_err", 32'(bus.err), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("clear_write_err_pulse", 32'(bus.err), 32'd0);
    wait_idle("clear_write_idle_timeout");
    cycle(0, 1, 0, 5'd0, 8'h00);
    check("clear_write_rdata", 32'(bus.rdata), 32'd0);
    check("clear_write_rv",    32'(bus.rvalid), 32'd1);

    // Fill, reset mid-operation, confirm full restart of the clear
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 5'(i), 8'($urandom_range(1, 255)));
    for (int i = 0; i < 9; i++)  cycle(0, 1, 0, 5'(i), 8'h00);
    reset_and_count(n);
    check("busy_len_midop", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 0, 5'(i), 8'h00);
      check("midop_read_val", 32'(bus.rdata), 32'd0);
    end

    // Reset during a read cancels the pending rvalid and zeroes rdata
    cycle(0, 0, 1, 5'd9, 8'h99);
    cycle(0, 1, 0, 5'd9, 8'h00);
    check("pre_reset_rdata", 32'(bus.rdata), 32'h99);
    cycle(1, 1, 0, 5'd9, 8'h00);
    check("reset_rdata_zero", 32'(bus.rdata), 32'd0);
    check("reset_rvalid_zero", 32'(bus.rvalid), 32'd0);
    wait_idle("reset_read_idle_timeout");

    // Randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 31)),
            8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_sync
